// File: rtl/risc_v_mike_mmio_arbiter.sv
// risc_v_mike_mmio_arbiter
//
// Purpose:
//   Two-requester arbiter and sequencer for the MMIO peripheral port.
//   Requester 0 is the core data-memory MMIO path. Requester 1 is a
//   secondary master, such as a debug or DMA engine. Ownership of the
//   shared port is granted round-robin. Each grant drives exactly one
//   single-cycle downstream access. The read data comes back registered,
//   together with a one-cycle response strobe to the owner.
//
//   Sequence per transaction:
//     edge T    : arbitration samples the reqN_* inputs (IDLE or RESP)
//     cycle T+1 : ACCESS -> gntN pulse and downstream mmio access
//     cycle T+2 : RESP   -> rspN_val pulse with rsp_rdata valid
//   Back-to-back throughput is one access every two cycles.
//
// Optional feature (compile-time macro RISC_V_MIKE_MMIO_ARB_LOCK_EN):
//   When the macro is defined, an owner whose latched request carried
//   lock=1 keeps the port if it asks again in RESP. A counter bounds this
//   at LOCK_MAX consecutive locked grants while the other side waits.
//   When the macro is undefined, the reqN_lock inputs are ignored and
//   arbitration is pure round-robin.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   reqN_val/wr/addr/wdata   request from requester N (held until gntN)
//   reqN_lock                keep ownership for the next request (lock build)
//   gntN                     one-cycle grant pulse (ACCESS cycle)
//   rspN_val                 one-cycle response pulse (RESP cycle)
//   rsp_rdata                shared registered response data (0 for writes)
//   mmio_val/wr/addr/wdata   downstream access, valid only in ACCESS
//   mmio_rdata               downstream combinational read data

module risc_v_mike_mmio_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_val,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  input  logic              req1_val,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp0_val,
  output logic              rsp1_val,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mmio_val,
  output logic              mmio_wr,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wdata,
  input  logic [DATA_W-1:0] mmio_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              rsp0_q;
  logic              rsp1_q;

  logic              win_val;
  logic              win_id;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifdef RISC_V_MIKE_MMIO_ARB_LOCK_EN
  localparam int              CNT_W   = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             lat_lock;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_nxt;
  logic             win_lock;
  logic             owner_req;
  logic             other_req;
`else
  // Without the lock feature, these inputs have no function.
  logic unused_lock;
  assign unused_lock = req0_lock ^ req1_lock ^ (LOCK_MAX != 0);
`endif

  // This block selects the winner from the inputs as they stand at the
  // arbitration edge. With a tie, the requester that did not own the
  // previous access wins. A locked owner may take precedence over that,
  // but only in RESP, and only until its lock budget runs out while the
  // other side is waiting.
  always_comb begin
    win_val = ((state == IDLE) || (state == RESP)) && (req0_val || req1_val);
    if (req0_val && req1_val) begin
      win_id = ~last_owner;
    end else begin
      win_id = req1_val;
    end

`ifdef RISC_V_MIKE_MMIO_ARB_LOCK_EN
    owner_req = owner ? req1_val : req0_val;
    other_req = owner ? req0_val : req1_val;
    if ((state == RESP) && lat_lock && owner_req &&
        !((lock_cnt >= CNT_MAX) && other_req)) begin
      win_id = owner;
    end
`endif

    win_wr    = win_id ? req1_wr    : req0_wr;
    win_addr  = win_id ? req1_addr  : req0_addr;
    win_wdata = win_id ? req1_wdata : req0_wdata;

`ifdef RISC_V_MIKE_MMIO_ARB_LOCK_EN
    // The counter tracks consecutive locked grants to the same owner.
    // It saturates so that it cannot wrap back under the limit.
    win_lock = win_id ? req1_lock : req0_lock;
    if (!win_lock) begin
      lock_cnt_nxt = '0;
    end else if (win_id != owner) begin
      lock_cnt_nxt = CNT_ONE;
    end else if (lock_cnt >= CNT_MAX) begin
      lock_cnt_nxt = lock_cnt;
    end else begin
      lock_cnt_nxt = lock_cnt + CNT_ONE;
    end
`endif
  end

  // This block holds the sequencer. A grant loads the request latch and
  // raises the grant strobe for the ACCESS cycle. ACCESS captures the
  // response data, with writes returning zero, and commits the
  // round-robin history. It then raises the response strobe for RESP.
  // Reset always wins, so any response that is in flight is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b1;
      last_owner <= 1'b1;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
`ifdef RISC_V_MIKE_MMIO_ARB_LOCK_EN
      lat_lock   <= 1'b0;
      lock_cnt   <= '0;
`endif
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (win_val) begin
            owner     <= win_id;
            lat_wr    <= win_wr;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            gnt0_q    <= ~win_id;
            gnt1_q    <= win_id;
`ifdef RISC_V_MIKE_MMIO_ARB_LOCK_EN
            lat_lock  <= win_lock;
            lock_cnt  <= lock_cnt_nxt;
`endif
            state     <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          rdata_q    <= lat_wr ? '0 : mmio_rdata;
          last_owner <= owner;
          rsp0_q     <= ~owner;
          rsp1_q     <= owner;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The strobes are gated by reset so that nothing is issued, granted or
  // answered in a reset cycle, even when reset arrives mid-access.
  assign gnt0       = gnt0_q & ~rst;
  assign gnt1       = gnt1_q & ~rst;
  assign rsp0_val   = rsp0_q & ~rst;
  assign rsp1_val   = rsp1_q & ~rst;
  assign rsp_rdata  = rdata_q;
  assign mmio_val   = (state == ACCESS) & ~rst;
  assign mmio_wr    = mmio_val & lat_wr;
  assign mmio_addr  = lat_addr;
  assign mmio_wdata = lat_wdata;

endmodule

// File: tb/tb_risc_v_mike_mmio_arbiter.sv
// tb_risc_v_mike_mmio_arbiter
//
// Self-checking bench for risc_v_mike_mmio_arbiter. Each scenario task
// drives requests and checks the grant and downstream access. It also
// pushes the expected response onto a scoreboard queue, which is popped
// when the response strobe arrives. Outputs are sampled on the falling
// clock edge. The lock scenario picks its expected grant order from
// RISC_V_MIKE_MMIO_ARB_LOCK_EN.

module tb_risc_v_mike_mmio_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_val, req0_wr, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_val, req1_wr, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic        gnt0, gnt1, rsp0_val, rsp1_val;
  logic [31:0] rsp_rdata;
  logic        mmio_val, mmio_wr;
  logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;

  // The slave model returns either a fixed word or the inverted address.
  logic        use_fixed;
  logic [31:0] fixed_rdata;
  assign mmio_rdata = use_fixed ? fixed_rdata : ~mmio_addr;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  risc_v_mike_mmio_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_lock(req0_lock),
    .req1_val(req1_val), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_lock(req1_lock),
    .gnt0(gnt0), .gnt1(gnt1), .rsp0_val(rsp0_val), .rsp1_val(rsp1_val),
    .rsp_rdata(rsp_rdata), .mmio_val(mmio_val), .mmio_wr(mmio_wr),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata)
  );

  always #5 clk = ~clk;

  // This watchdog stops a run that somehow never reaches its summary line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task set_req(input bit id, input logic wr, input logic [31:0] addr,
               input logic [31:0] wdata, input logic lock);
    if (id == 1'b0) begin
      req0_val = 1'b1; req0_wr = wr; req0_addr = addr; req0_wdata = wdata; req0_lock = lock;
    end else begin
      req1_val = 1'b1; req1_wr = wr; req1_addr = addr; req1_wdata = wdata; req1_lock = lock;
    end
  endtask

  task drop_req(input bit id);
    if (id == 1'b0) req0_val = 1'b0;
    else            req1_val = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1; use_fixed = 1'b0; fixed_rdata = '0;
    req0_val = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0; req0_lock = 0;
    req1_val = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0; req1_lock = 0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({gnt0, gnt1, rsp0_val, rsp1_val, mmio_val, mmio_wr} !== 6'b0)
      $display("[TB] FAIL reset_strobes: got %b want 000000",
               {gnt0, gnt1, rsp0_val, rsp1_val, mmio_val, mmio_wr});
    else pass_cnt++;
    total_cnt++;
    if ({mmio_addr, mmio_wdata, rsp_rdata} !== 96'b0)
      $display("[TB] FAIL reset_data: got %h %h %h want 0", mmio_addr, mmio_wdata, rsp_rdata);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task test_write;
    set_req(1'b0, 1'b1, 32'h0, 32'hA5, 1'b0);
    @(negedge clk);
    total_cnt++;
    if ({gnt1, gnt0} !== 2'b01) $display("[TB] FAIL write_gnt: got %b want 01", {gnt1, gnt0});
    else pass_cnt++;
    total_cnt++;
    if ({mmio_val, mmio_wr} !== 2'b11) $display("[TB] FAIL write_mmio_ctl: got %b want 11", {mmio_val, mmio_wr});
    else pass_cnt++;
    total_cnt++;
    if (mmio_addr !== 32'h0) $display("[TB] FAIL write_addr: got %h want 0", mmio_addr);
    else pass_cnt++;
    total_cnt++;
    if (mmio_wdata !== 32'hA5) $display("[TB] FAIL write_wdata: got %h want a5", mmio_wdata);
    else pass_cnt++;
    exp_q.push_back('{id: 1'b0, data: 32'h0});
    drop_req(1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if ({rsp1_val, rsp0_val} !== (e.id ? 2'b10 : 2'b01))
      $display("[TB] FAIL write_rsp: got %b want owner %0d", {rsp1_val, rsp0_val}, e.id);
    else pass_cnt++;
    total_cnt++;
    if (rsp_rdata !== e.data) $display("[TB] FAIL write_rdata: got %h want %h", rsp_rdata, e.data);
    else pass_cnt++;
    total_cnt++;
    if (mmio_val !== 1'b0) $display("[TB] FAIL write_resp_mmio: got %b want 0", mmio_val);
    else pass_cnt++;
  endtask

  task test_read;
    use_fixed = 1'b1; fixed_rdata = 32'h3C;
    set_req(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if ({gnt1, gnt0} !== 2'b10) $display("[TB] FAIL read_gnt: got %b want 10", {gnt1, gnt0});
    else pass_cnt++;
    total_cnt++;
    if ({mmio_val, mmio_wr} !== 2'b10) $display("[TB] FAIL read_mmio_ctl: got %b want 10", {mmio_val, mmio_wr});
    else pass_cnt++;
    total_cnt++;
    if (mmio_addr !== 32'h4) $display("[TB] FAIL read_addr: got %h want 4", mmio_addr);
    else pass_cnt++;
    exp_q.push_back('{id: 1'b1, data: 32'h3C});
    drop_req(1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if ({rsp1_val, rsp0_val} !== (e.id ? 2'b10 : 2'b01))
      $display("[TB] FAIL read_rsp: got %b want owner %0d", {rsp1_val, rsp0_val}, e.id);
    else pass_cnt++;
    total_cnt++;
    if (rsp_rdata !== e.data) $display("[TB] FAIL read_rdata: got %h want %h", rsp_rdata, e.data);
    else pass_cnt++;
    fixed_rdata = 32'h77;
    @(negedge clk);
    total_cnt++;
    if (rsp_rdata !== 32'h3C) $display("[TB] FAIL read_hold: got %h want 3c", rsp_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({rsp1_val, rsp0_val} !== 2'b00) $display("[TB] FAIL read_rsp_once: got %b want 00", {rsp1_val, rsp0_val});
    else pass_cnt++;
    use_fixed = 1'b0;
  endtask

  task test_back_to_back;
    logic [31:0] a0, a1, ga;
    bit          exp_id;
    a0 = 32'h100; a1 = 32'h200; exp_id = 1'b0;
    set_req(1'b0, 1'b0, a0, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, a1, 32'h0, 1'b0);
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      ga = exp_id ? a1 : a0;
      total_cnt++;
      if ({gnt1, gnt0} !== (exp_id ? 2'b10 : 2'b01))
        $display("[TB] FAIL b2b_gnt%0d: got %b want owner %0d", g, {gnt1, gnt0}, exp_id);
      else pass_cnt++;
      total_cnt++;
      if (mmio_addr !== ga) $display("[TB] FAIL b2b_addr%0d: got %h want %h", g, mmio_addr, ga);
      else pass_cnt++;
      exp_q.push_back('{id: exp_id, data: ~ga});
      if (exp_id == 1'b0) begin
        a0 = a0 + 32'h4;
        if (g >= 6) drop_req(1'b0); else set_req(1'b0, 1'b0, a0, 32'h0, 1'b0);
      end else begin
        a1 = a1 + 32'h4;
        if (g >= 6) drop_req(1'b1); else set_req(1'b1, 1'b0, a1, 32'h0, 1'b0);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      total_cnt++;
      if ({rsp1_val, rsp0_val} !== (e.id ? 2'b10 : 2'b01))
        $display("[TB] FAIL b2b_rsp%0d: got %b want owner %0d", g, {rsp1_val, rsp0_val}, e.id);
      else pass_cnt++;
      total_cnt++;
      if (rsp_rdata !== e.data) $display("[TB] FAIL b2b_rdata%0d: got %h want %h", g, rsp_rdata, e.data);
      else pass_cnt++;
      total_cnt++;
      if ({gnt1, gnt0} !== 2'b00) $display("[TB] FAIL b2b_gap%0d: got %b want 00", g, {gnt1, gnt0});
      else pass_cnt++;
      exp_id = ~exp_id;
    end
    @(negedge clk);
    total_cnt++;
    if (mmio_val !== 1'b0) $display("[TB] FAIL b2b_idle: got %b want 0", mmio_val);
    else pass_cnt++;
  endtask

  task test_reset_in_access;
    set_req(1'b0, 1'b1, 32'h10, 32'h11, 1'b0);
    @(negedge clk);
    total_cnt++;
    if ({gnt1, gnt0} !== 2'b01) $display("[TB] FAIL rstacc_pre_gnt: got %b want 01", {gnt1, gnt0});
    else pass_cnt++;
    exp_q.push_back('{id: 1'b0, data: 32'h0});
    drop_req(1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if ({rsp1_val, rsp0_val} !== (e.id ? 2'b10 : 2'b01))
      $display("[TB] FAIL rstacc_pre_rsp: got %b want owner %0d", {rsp1_val, rsp0_val}, e.id);
    else pass_cnt++;
    set_req(1'b1, 1'b1, 32'h20, 32'h22, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({mmio_val, mmio_wr} !== 2'b00) $display("[TB] FAIL rstacc_mmio: got %b want 00", {mmio_val, mmio_wr});
    else pass_cnt++;
    drop_req(1'b1);
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({rsp1_val, rsp0_val, mmio_val} !== 3'b000)
      $display("[TB] FAIL rstacc_no_rsp: got %b want 000", {rsp1_val, rsp0_val, mmio_val});
    else pass_cnt++;
    set_req(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 32'h34, 32'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if ({gnt1, gnt0} !== 2'b01) $display("[TB] FAIL rstacc_tie_gnt0: got %b want 01", {gnt1, gnt0});
    else pass_cnt++;
    exp_q.push_back('{id: 1'b0, data: ~32'h30});
    drop_req(1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if (({rsp1_val, rsp0_val} !== (e.id ? 2'b10 : 2'b01)) || (rsp_rdata !== e.data))
      $display("[TB] FAIL rstacc_tie_rsp0: got %b/%h want owner %0d/%h",
               {rsp1_val, rsp0_val}, rsp_rdata, e.id, e.data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({gnt1, gnt0} !== 2'b10) $display("[TB] FAIL rstacc_tie_gnt1: got %b want 10", {gnt1, gnt0});
    else pass_cnt++;
    exp_q.push_back('{id: 1'b1, data: ~32'h34});
    drop_req(1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if (({rsp1_val, rsp0_val} !== (e.id ? 2'b10 : 2'b01)) || (rsp_rdata !== e.data))
      $display("[TB] FAIL rstacc_tie_rsp1: got %b/%h want owner %0d/%h",
               {rsp1_val, rsp0_val}, rsp_rdata, e.id, e.data);
    else pass_cnt++;
  endtask

  task test_lock;
    bit          exp_seq [6];
    logic [31:0] a0, a1, ga;
`ifdef RISC_V_MIKE_MMIO_ARB_LOCK_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    a0 = 32'h300; a1 = 32'h400;
    set_req(1'b0, 1'b0, a0, 32'h0, 1'b1);
    set_req(1'b1, 1'b0, a1, 32'h0, 1'b0);
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      ga = exp_seq[g] ? a1 : a0;
      total_cnt++;
      if ({gnt1, gnt0} !== (exp_seq[g] ? 2'b10 : 2'b01))
        $display("[TB] FAIL lock_gnt%0d: got %b want owner %0d", g, {gnt1, gnt0}, exp_seq[g]);
      else pass_cnt++;
      exp_q.push_back('{id: exp_seq[g], data: ~ga});
      if (exp_seq[g] == 1'b0) begin
        a0 = a0 + 32'h4;
        set_req(1'b0, 1'b0, a0, 32'h0, 1'b1);
      end else begin
        a1 = a1 + 32'h4;
        set_req(1'b1, 1'b0, a1, 32'h0, 1'b0);
      end
      if (g == 5) begin
        drop_req(1'b0);
        drop_req(1'b1);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      total_cnt++;
      if (({rsp1_val, rsp0_val} !== (e.id ? 2'b10 : 2'b01)) || (rsp_rdata !== e.data))
        $display("[TB] FAIL lock_rsp%0d: got %b/%h want owner %0d/%h",
                 g, {rsp1_val, rsp0_val}, rsp_rdata, e.id, e.data);
      else pass_cnt++;
    end
    req0_lock = 1'b0;
    @(negedge clk);
  endtask

  task test_idle_gap;
    logic        wr;
    logic [31:0] addr;
    for (int k = 0; k < 4; k++) begin
      wr   = k[0];
      addr = 32'h500 + 32'(4 * k);
      set_req(1'b1, wr, addr, 32'h1000 + 32'(k), 1'b0);
      @(negedge clk);
      total_cnt++;
      if ({gnt1, gnt0} !== 2'b10) $display("[TB] FAIL gap_gnt%0d: got %b want 10", k, {gnt1, gnt0});
      else pass_cnt++;
      total_cnt++;
      if ({mmio_wr, mmio_addr} !== {wr, addr})
        $display("[TB] FAIL gap_access%0d: got %b/%h want %b/%h", k, mmio_wr, mmio_addr, wr, addr);
      else pass_cnt++;
      exp_q.push_back('{id: 1'b1, data: (wr ? 32'h0 : ~addr)});
      drop_req(1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      total_cnt++;
      if (({rsp1_val, rsp0_val} !== (e.id ? 2'b10 : 2'b01)) || (rsp_rdata !== e.data))
        $display("[TB] FAIL gap_rsp%0d: got %b/%h want owner %0d/%h",
                 k, {rsp1_val, rsp0_val}, rsp_rdata, e.id, e.data);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({mmio_val, gnt1, gnt0} !== 3'b000)
        $display("[TB] FAIL gap_idle%0d: got %b want 000", k, {mmio_val, gnt1, gnt0});
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_in_access();
    test_lock();
    test_idle_gap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
